// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the pipelined RISC-V core.
// Owns the fetch PC, issues one-cycle-latency word reads to instruction
// memory, buffers returned words with their PCs in a small prefetch FIFO
// and hands them to decode through a valid/ready handshake. A redirect
// from execute flushes everything buffered or in flight and restarts fetch.
module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect_en,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             instr_ready
);

    localparam int               AW        = $clog2(DEPTH);
    localparam logic [AW:0]      DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [WIDTH-1:0] PC_STEP   = WIDTH'(4);

    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] inflight_pc;
    logic             inflight;
    logic             kill;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] fifo_pc    [DEPTH];
    logic [WIDTH-1:0] fifo_instr [DEPTH];

    logic [AW:0]      occupancy;
    logic             req_int;
    logic             push;
    logic             pop;
    logic             unused_pc_bits;

    // The low two bits of a redirect target are dropped (word alignment).
    assign unused_pc_bits = ^redirect_pc[1:0];

    // Request/push/pop decisions and head outputs; buffered plus in-flight
    // words may never exceed the FIFO size, so a response always has room.
    always_comb begin
        occupancy   = count + {{AW{1'b0}}, inflight};
        req_int     = !redirect_en && (occupancy < DEPTH_CNT);
        imem_req    = rst && req_int;
        imem_addr   = rst ? fetch_pc : '0;
        push        = imem_rvalid && inflight && !kill && !redirect_en;
        instr_valid = (count != '0);
        pop         = instr_valid && instr_ready && !redirect_en;
        instr       = instr_valid ? fifo_instr[rd_ptr] : '0;
        instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : '0;
    end

    // Fetch PC, outstanding-request tracking and FIFO bookkeeping; a redirect
    // overrides any simultaneous request, response or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            kill        <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect_en) begin
            fetch_pc <= {redirect_pc[WIDTH-1:2], 2'b00};
            kill     <= inflight;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (req_int) begin
                fetch_pc    <= fetch_pc + PC_STEP;
                inflight    <= 1'b1;
                inflight_pc <= fetch_pc;
                kill        <= 1'b0;
            end else begin
                inflight <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: returned word is written with the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= inflight_pc;
            fifo_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a
// stream-level model: decode must see consecutive PCs from the last restart
// point, each word appearing two cycles after its request.
module tb_fetch_unit;

    localparam int          WIDTH    = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h100;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    // Model state: head PC expected by decode, and the issue cycle of every
    // word requested since the last restart that decode has not yet taken.
    int          now;
    logic [31:0] exp_pc;
    int          req_cycle[$];
    logic        exp_valid;
    logic        exp_req;
    logic        spurious;

    logic        o_req;
    logic        o_valid;
    logic        o_pop;
    logic [31:0] o_addr;
    logic [31:0] o_instr;
    logic [31:0] o_pc;

    logic [31:0] wrap_seen[4];
    int          nwrap;
    int          nreq;

    fetch_unit #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_restart(input logic [31:0] start);
        exp_pc = start;
        req_cycle.delete();
        now = 0;
    endtask

    // Drive this cycle's inputs, sample outputs and compare with the model.
    task automatic apply_stimulus(input logic ready, input logic redir,
                                  input logic [31:0] rpc, input logic junk);
        instr_ready = ready;
        redirect_en = redir;
        redirect_pc = rpc;
        spurious    = junk;
        #1;
        o_req   = imem_req;
        o_addr  = imem_addr;
        o_valid = instr_valid;
        o_instr = instr;
        o_pc    = instr_pc;
        exp_valid = 1'b0;
        if (req_cycle.size() > 0) begin
            exp_valid = (req_cycle[0] + 2 <= now);
        end
        check_output("instr_valid", {31'b0, o_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            check_output("instr_pc", o_pc, exp_pc);
            check_output("instr", o_instr, exp_pc ^ KEY);
        end else begin
            check_output("idle_instr_pc", o_pc, 32'h0);
            check_output("idle_instr", o_instr, 32'h0);
        end
        exp_req = !redir && (req_cycle.size() < DEPTH);
        check_output("imem_req", {31'b0, o_req}, {31'b0, exp_req});
        if (o_req) begin
            check_output("imem_addr", o_addr, exp_pc + 32'(req_cycle.size() * 4));
        end
        o_pop = exp_valid && ready;
    endtask

    // Advance one clock, update the model and play the memory's response.
    task automatic advance_clock();
        @(posedge clk);
        if (redirect_en) begin
            model_restart({redirect_pc[31:2], 2'b00});
            now = -1;
        end else begin
            if (o_pop) begin
                void'(req_cycle.pop_front());
                exp_pc = exp_pc + 32'd4;
            end
            if (exp_req) begin
                req_cycle.push_back(now);
            end
        end
        now++;
        #1;
        imem_rvalid = o_req || spurious;
        imem_rdata  = o_req ? (o_addr ^ KEY) : $urandom;
        @(negedge clk);
    endtask

    // Assert reset between clock edges, check outputs clear at once, release.
    task automatic do_reset();
        #2;
        rst         = 1'b0;
        imem_rvalid = 1'b0;
        redirect_en = 1'b0;
        #1;
        check_output("rst_imem_req", {31'b0, imem_req}, 32'h0);
        check_output("rst_imem_addr", imem_addr, 32'h0);
        check_output("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        check_output("rst_instr", instr, 32'h0);
        check_output("rst_instr_pc", instr_pc, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        model_restart(RESET_PC);
    endtask

    initial begin
        $display("[TB] fetch_unit bench start");
        @(negedge clk);
        do_reset();

        // Reset sequencing with decode always ready.
        for (int c = 0; c < 14; c++) begin
            apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0);
            if (c == 0) begin
                check_output("c0_req", {31'b0, o_req}, 32'h1);
                check_output("c0_addr", o_addr, 32'h100);
            end
            if (c == 1) check_output("c1_valid", {31'b0, o_valid}, 32'h0);
            if (c == 2) check_output("c2_pc", o_pc, 32'h100);
            if (c >= 2) check_output("no_bubble", {31'b0, o_valid}, 32'h1);
            advance_clock();
        end

        // Fill the FIFO, poke spurious responses, then reset while full.
        for (int c = 0; c < 8; c++) begin
            apply_stimulus(1'b0, 1'b0, 32'h0, (c >= 5));
            advance_clock();
        end
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
        check_output("full_before_reset", {31'b0, o_valid}, 32'h1);
        do_reset();

        // Back-pressure from cycle 2 for ten cycles, then release.
        nreq = 0;
        for (int c = 0; c < 22; c++) begin
            apply_stimulus((c < 2 || c >= 12), 1'b0, 32'h0, 1'b0);
            if (c < 12 && o_req) nreq++;
            if (c >= 2 && c < 12) check_output("stall_head", o_pc, 32'h100);
            if (c == 12) check_output("resume_wait", {31'b0, o_req}, 32'h0);
            if (c == 13) check_output("resume_req", {31'b0, o_req}, 32'h1);
            advance_clock();
        end
        check_output("stall_req_count", 32'(nreq), 32'(DEPTH));

        // Redirect with a request in flight and two words buffered.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            apply_stimulus((c == 3 || c == 4 || c >= 6), (c == 5), 32'h203, 1'b0);
            if (c == 5) check_output("redir_req", {31'b0, o_req}, 32'h0);
            if (c == 6) check_output("redir_addr", o_addr, 32'h200);
            if (c == 6 || c == 7) check_output("redir_gap", {31'b0, o_valid}, 32'h0);
            if (c == 8) check_output("redir_pc", o_pc, 32'h200);
            advance_clock();
        end

        // Redirect coinciding with a pop and a response, to a wrapping target.
        apply_stimulus(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
        check_output("simul_valid", {31'b0, o_valid}, 32'h1);
        check_output("simul_req", {31'b0, o_req}, 32'h0);
        advance_clock();
        nwrap = 0;
        for (int c = 0; c < 20; c++) begin
            apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0);
            if (c == 0) check_output("simul_empty", {31'b0, o_valid}, 32'h0);
            if (o_valid && nwrap < 4) begin
                wrap_seen[nwrap] = o_pc;
                nwrap++;
            end
            advance_clock();
        end
        check_output("wrap_count", 32'(nwrap), 32'd4);
        check_output("wrap_pc0", wrap_seen[0], 32'hFFFF_FFF8);
        check_output("wrap_pc1", wrap_seen[1], 32'hFFFF_FFFC);
        check_output("wrap_pc2", wrap_seen[2], 32'h0000_0000);
        check_output("wrap_pc3", wrap_seen[3], 32'h0000_0004);

        // Randomized traffic: stalls, redirects and stray memory responses.
        for (int c = 0; c < 400; c++) begin
            logic        r_ready;
            logic        r_redir;
            logic [31:0] r_pc;
            r_ready = ($urandom_range(0, 3) != 0);
            r_redir = ($urandom_range(0, 15) == 0);
            r_pc    = $urandom;
            if ($urandom_range(0, 3) == 0) r_pc = 32'hFFFF_FFF0 | (r_pc & 32'hF);
            apply_stimulus(r_ready, r_redir, r_pc, ($urandom_range(0, 1) == 1));
            advance_clock();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that feeds the IF/ID instruction register of the pipelined RISC-V core. It owns the fetch PC and issues word reads to the instruction memory, which has a fixed one-cycle read latency. Returned words are buffered with their PCs in a small prefetch FIFO and presented to decode through a valid/ready handshake (ready = `pipeline_advance`). Branch and jump redirects from execute flush all buffered and in-flight fetches and restart fetch at the target.

## Interface
- `WIDTH`, 32: instruction and address width.
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2. ≥3 is required for 1 instr/cycle throughput.
- `RESET_PC`, 32'h0: first fetch address after reset.

One clock; reset is asynchronous and active-low.

- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous active-low reset.
- `imem_req`, out, 1: read request this cycle.
- `imem_addr`, out, WIDTH: word address of the request; bits [1:0] are always 0.
- `imem_rvalid`, in, 1: read data valid; asserted exactly one cycle after `imem_req`.
- `imem_rdata`, in, WIDTH: instruction word returned by memory.
- `redirect_en`, in, 1: flush and restart fetch.
- `redirect_pc`, in, WIDTH: restart address; bits [1:0] are ignored (treated as 0).
- `instr_valid`, out, 1: FIFO head is valid.
- `instr`, out, WIDTH: FIFO head instruction; 0 when `instr_valid`=0.
- `instr_pc`, out, WIDTH: PC of `instr`; 0 when `instr_valid`=0.
- `instr_ready`, in, 1: decode accepts the head this cycle (`pipeline_advance`).

## Operation
- State:
  - `fetch_pc`: next address to request.
  - FIFO of {pc, instr}, with rd/wr pointers and `count`.
  - `inflight`: 1 bit, a request is outstanding.
  - `inflight_pc`.
  - `kill`: 1 bit, discard the outstanding response.
- Request: `imem_req` = !`redirect_en` && (`count` + `inflight`) < DEPTH. This is combinational from state plus `redirect_en`. `imem_addr` = `fetch_pc`.
- On request:
  - `fetch_pc` <= `fetch_pc` + 4, modulo 2^WIDTH (32'hFFFF_FFFC wraps to 0).
  - `inflight` <= 1, `inflight_pc` <= `fetch_pc`, `kill` <= 0.
  - With no request, `inflight` <= 0.
- Response: `imem_rvalid` && !`kill` && !`redirect_en` pushes {`inflight_pc`, `imem_rdata`}. The space check guarantees there is no push into a full FIFO.
- Pop: `instr_valid` && `instr_ready` advances the read pointer.
- Push and pop in the same cycle leave `count` unchanged.
- Redirect (`redirect_en`=1 in cycle t):
  - `count`, pointers <= 0.
  - `fetch_pc` <= {`redirect_pc`[WIDTH-1:2], 2'b00}.
  - `kill` <= `inflight`.
  - No request and no push occur in cycle t.
  - Redirect has priority over a simultaneous pop, push or response. A pop in cycle t still counts as accepted by decode.
- `imem_rvalid` while `inflight`=0 is a memory protocol error and is ignored (no push).
- Asynchronous reset, effective immediately mid-operation:
  - `fetch_pc`=RESET_PC; FIFO empty; `inflight`=0; `kill`=0.
  - Outputs: `imem_req`=0, `imem_addr`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0.
  - `imem_req`/`imem_addr` are forced to 0 only while `rst`=0.

## Timing
- Reset released before edge 0:
  - Cycle 0: `imem_req`=1, `imem_addr`=RESET_PC.
  - Cycle 1: response arrives and is pushed.
  - Cycle 2: `instr_valid`=1. Fetch-to-decode latency is 2 cycles.
- Redirect asserted in cycle t:
  - Cycle t+1: first request to the target.
  - Cycle t+3: `instr_valid` for the target instruction.
  - `instr_valid`=0 in cycles t+1 and t+2.
- Steady state with `instr_ready`=1 and DEPTH≥3: one request and one instruction per cycle, PCs consecutive +4.
- Decode stall (`instr_ready`=0): the FIFO fills.
  - Requests stop once `count` + `inflight` = DEPTH.
  - Head outputs are held stable.
  - Requests resume the cycle after the first pop.
- The FIFO head drives `instr`/`instr_pc` combinationally from registers; there is no input-to-output combinational path except `redirect_en` to `imem_req`.

## Test plan
- Reset sequencing:
  - Stimulus: RESET_PC=32'h100, memory word at A = A ^ 32'hA5A5_0000, `instr_ready`=1 throughout.
  - Response: cycle 2 shows `instr_pc`=32'h100; every following cycle shows PC +4 with matching data; no bubbles.
- Back-pressure:
  - Stimulus: hold `instr_ready`=0 for 10 cycles from cycle 2, then release.
  - Response: at most DEPTH requests are issued; the head stays at 32'h100 throughout the stall; after release, PCs continue in order with no gaps or duplicates.
- Redirect with in-flight fetch:
  - Stimulus: in cycle 5, with `inflight`=1 and `count`=2, pulse `redirect_en` with `redirect_pc`=32'h203.
  - Response: cycles 6–7 show `instr_valid`=0; cycle 8 shows `instr_pc`=32'h200; none of the old PCs ever appear.
- Simultaneous events:
  - Stimulus: a redirect coinciding with a pop and with an `imem_rvalid` response.
  - Response: no push occurs; the FIFO is empty the next cycle; `imem_req`=0 in the redirect cycle.
- Wrap-around:
  - Stimulus: redirect to 32'hFFFF_FFF8.
  - Response: delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Mid-operation reset:
  - Stimulus: assert `rst`=0 asynchronously, between clock edges, while the FIFO is full.
  - Response: all outputs go to 0 immediately; after release, fetch restarts at RESET_PC.
